// File: rtl/ad7124_frame_pkg.sv
// Shared definitions for the AD7124 measurement frame: magic word, header layout,
// parser states and the frame-length rule used by both the writer and the reader.
package ad7124_frame_pkg;

    localparam logic [31:0] FRAME_MAGIC = 32'h44415441;  // "DATA"
    localparam int HDR_WORDS     = 6;
    localparam int HDR_OFF_ID    = 2;
    localparam int HDR_OFF_COUNT = 3;
    localparam int HDR_OFF_SEC   = 4;
    localparam int HDR_OFF_NSEC  = 5;

    typedef enum logic [1:0] {
        S_MAGIC = 2'd0,
        S_LEN   = 2'd1,
        S_HDR   = 2'd2,
        S_PAY   = 2'd3
    } state_t;

    function automatic int frame_length(input int boards, input int tc, input int rtd);
        return HDR_WORDS + boards * (tc + rtd);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/ad7124_fifo_prefetch.sv
// Two-entry prefetch buffer in front of a read-latency-1 FIFO, presenting the
// words as a valid/ready stream to the frame parser.
module ad7124_fifo_prefetch (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    output logic        fifo_rd_en,
    input  logic [31:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    logic [31:0] buf_mem [2];
    logic        wr_ptr_reg;
    logic        rd_ptr_reg;
    logic [1:0]  count_reg;
    logic        inflight_reg;
    logic        pop;
    logic [1:0]  committed;

    assign out_valid = (count_reg != 2'd0);
    assign out_data  = buf_mem[rd_ptr_reg];
    assign pop       = out_valid && out_ready;

    // A word leaving this cycle frees its slot immediately, so a steady
    // consumer sees one word per cycle instead of two every three.
    assign committed  = count_reg + {1'b0, inflight_reg} - {1'b0, pop};
    assign fifo_rd_en = resetn && !clear && !fifo_empty && (committed < 2'd2);

    always_ff @(posedge clk) begin
        if (inflight_reg) begin
            buf_mem[wr_ptr_reg] <= fifo_dout;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            inflight_reg <= 1'b0;
        end else if (clear) begin
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= fifo_rd_en;
            if (inflight_reg) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, inflight_reg} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/axi_ad7124_frame_unpack.sv
// Frame parser: locks onto the magic word, validates the length, latches the
// header and streams the TC/RTD payload on AXI-Stream tagged with its channel index.
module axi_ad7124_frame_unpack
    import ad7124_frame_pkg::*;
#(
    parameter int NUM_OF_BOARD  = 6,
    parameter int TC_PER_BOARD  = 8,
    parameter int RTD_PER_BOARD = 10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ctrl_reset,
    output logic        fifo_rd_en,
    input  logic [31:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic [7:0]  m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        hdr_valid,
    output logic [31:0] hdr_measure_id,
    output logic [31:0] hdr_measure_count,
    output logic [31:0] hdr_ts_sec,
    output logic [31:0] hdr_ts_nsec,
    output logic [31:0] stat_frame_cnt,
    output logic [15:0] stat_err_cnt,
    output logic [1:0]  stat_state
);

    localparam int          FRAME_LENGTH   = frame_length(NUM_OF_BOARD, TC_PER_BOARD, RTD_PER_BOARD);
    localparam logic [31:0] FRAME_LEN_WORD = 32'(FRAME_LENGTH);
    localparam logic [7:0]  LAST_IDX       = 8'(FRAME_LENGTH - HDR_WORDS - 1);

    state_t      state_reg;
    logic        hunting_reg;
    logic [2:0]  hdr_pos_reg;
    logic [7:0]  pay_idx_reg;
    logic [31:0] shadow_reg [HDR_OFF_ID:HDR_OFF_NSEC];

    logic        buf_valid;
    logic        buf_ready;
    logic [31:0] buf_data;
    logic        take;
    logic        load_ok;
    logic        tlast_hs;

    ad7124_fifo_prefetch u_prefetch (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (ctrl_reset),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .out_valid  (buf_valid),
        .out_ready  (buf_ready),
        .out_data   (buf_data)
    );

    // The output register refills only while it is empty or draining a non-last
    // beat; after tlast the next frame's magic stays buffered until the handshake.
    assign load_ok   = !m_axis_tvalid || (m_axis_tready && !m_axis_tlast);
    assign buf_ready = (state_reg != S_PAY) || load_ok;
    assign take      = buf_valid && buf_ready;
    assign tlast_hs  = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign stat_state = state_reg;

    always_ff @(posedge clk) begin
        if (take && state_reg == S_HDR) begin
            shadow_reg[hdr_pos_reg] <= buf_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg         <= S_MAGIC;
            hunting_reg       <= 1'b0;
            hdr_pos_reg       <= 3'd0;
            pay_idx_reg       <= 8'd0;
            m_axis_tvalid     <= 1'b0;
            m_axis_tdata      <= 32'd0;
            m_axis_tuser      <= 8'd0;
            m_axis_tlast      <= 1'b0;
            hdr_valid         <= 1'b0;
            hdr_measure_id    <= 32'd0;
            hdr_measure_count <= 32'd0;
            hdr_ts_sec        <= 32'd0;
            hdr_ts_nsec       <= 32'd0;
            stat_frame_cnt    <= 32'd0;
            stat_err_cnt      <= 16'd0;
        end else if (ctrl_reset) begin
            state_reg         <= S_MAGIC;
            hunting_reg       <= 1'b0;
            hdr_pos_reg       <= 3'd0;
            pay_idx_reg       <= 8'd0;
            m_axis_tvalid     <= 1'b0;
            m_axis_tdata      <= 32'd0;
            m_axis_tuser      <= 8'd0;
            m_axis_tlast      <= 1'b0;
            hdr_valid         <= 1'b0;
            hdr_measure_id    <= 32'd0;
            hdr_measure_count <= 32'd0;
            hdr_ts_sec        <= 32'd0;
            hdr_ts_nsec       <= 32'd0;
            stat_frame_cnt    <= 32'd0;
            stat_err_cnt      <= 16'd0;
        end else begin
            hdr_valid <= 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (tlast_hs) begin
                stat_frame_cnt <= stat_frame_cnt + 32'd1;
            end

            case (state_reg)
                S_MAGIC: begin
                    if (take) begin
                        if (buf_data == FRAME_MAGIC) begin
                            state_reg   <= S_LEN;
                            hunting_reg <= 1'b0;
                        end else if (!hunting_reg) begin
                            stat_err_cnt <= sat_inc16(stat_err_cnt);
                            hunting_reg  <= 1'b1;
                        end
                    end
                end
                S_LEN: begin
                    if (take) begin
                        if (buf_data == FRAME_LEN_WORD) begin
                            state_reg   <= S_HDR;
                            hdr_pos_reg <= 3'(HDR_OFF_ID);
                        end else begin
                            stat_err_cnt <= sat_inc16(stat_err_cnt);
                            state_reg    <= S_MAGIC;
                        end
                    end
                end
                S_HDR: begin
                    if (take) begin
                        hdr_pos_reg <= hdr_pos_reg + 3'd1;
                        if (hdr_pos_reg == 3'(HDR_OFF_NSEC)) begin
                            hdr_measure_id    <= shadow_reg[HDR_OFF_ID];
                            hdr_measure_count <= shadow_reg[HDR_OFF_COUNT];
                            hdr_ts_sec        <= shadow_reg[HDR_OFF_SEC];
                            hdr_ts_nsec       <= buf_data;
                            hdr_valid         <= 1'b1;
                            pay_idx_reg       <= 8'd0;
                            state_reg         <= S_PAY;
                        end
                    end
                end
                S_PAY: begin
                    if (take) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= buf_data;
                        m_axis_tuser  <= pay_idx_reg;
                        m_axis_tlast  <= (pay_idx_reg == LAST_IDX);
                        pay_idx_reg   <= pay_idx_reg + 8'd1;
                    end else if (tlast_hs) begin
                        state_reg <= S_MAGIC;
                    end
                end
                default: state_reg <= S_MAGIC;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ad7124_frame_unpack.sv
// Randomized bench for the frame parser: a queue-driven FIFO source, a random-ready
// sink and a word-level reference parser that predicts beats, headers and counters.
module tb_axi_ad7124_frame_unpack;

    localparam logic [31:0] MAGIC = 32'h44415441;
    localparam int FLEN = 114;
    localparam int NPAY = FLEN - 6;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ctrl_reset;
    logic        fifo_rd_en;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [7:0]  m_axis_tuser;
    logic        m_axis_tlast;
    logic        hdr_valid;
    logic [31:0] hdr_measure_id;
    logic [31:0] hdr_measure_count;
    logic [31:0] hdr_ts_sec;
    logic [31:0] hdr_ts_nsec;
    logic [31:0] stat_frame_cnt;
    logic [15:0] stat_err_cnt;
    logic [1:0]  stat_state;

    always #5 clk = ~clk;

    axi_ad7124_frame_unpack dut (
        .clk               (clk),
        .resetn            (resetn),
        .ctrl_reset        (ctrl_reset),
        .fifo_rd_en        (fifo_rd_en),
        .fifo_dout         (fifo_dout),
        .fifo_empty        (fifo_empty),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tuser      (m_axis_tuser),
        .m_axis_tlast      (m_axis_tlast),
        .hdr_valid         (hdr_valid),
        .hdr_measure_id    (hdr_measure_id),
        .hdr_measure_count (hdr_measure_count),
        .hdr_ts_sec        (hdr_ts_sec),
        .hdr_ts_nsec       (hdr_ts_nsec),
        .stat_frame_cnt    (stat_frame_cnt),
        .stat_err_cnt      (stat_err_cnt),
        .stat_state        (stat_state)
    );

    typedef struct {
        logic [31:0] data;
        logic [7:0]  user;
        logic        last;
    } beat_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] stim_q[$];
    logic [31:0] src_q[$];
    beat_t       exp_beats[$];
    logic [31:0] exp_hdr[$];
    int          exp_hdr_cnt;
    int          exp_err;
    int          exp_frames;
    int          hdr_seen;
    int          gap_pct;
    int          ready_pct;
    logic        prev_stall;
    logic        prev_rd;
    beat_t       held;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tvalid"}, {31'd0, m_axis_tvalid}, 32'd0);
        check({tag, "_tdata"}, m_axis_tdata, 32'd0);
        check({tag, "_tuser"}, {24'd0, m_axis_tuser}, 32'd0);
        check({tag, "_tlast"}, {31'd0, m_axis_tlast}, 32'd0);
        check({tag, "_hdr_valid"}, {31'd0, hdr_valid}, 32'd0);
        check({tag, "_hdr_id"}, hdr_measure_id, 32'd0);
        check({tag, "_hdr_cnt"}, hdr_measure_count, 32'd0);
        check({tag, "_hdr_sec"}, hdr_ts_sec, 32'd0);
        check({tag, "_hdr_nsec"}, hdr_ts_nsec, 32'd0);
        check({tag, "_frame_cnt"}, stat_frame_cnt, 32'd0);
        check({tag, "_err_cnt"}, {16'd0, stat_err_cnt}, 32'd0);
        check({tag, "_state"}, {30'd0, stat_state}, 32'd0);
    endtask

    // One clock: observe registered outputs, drive new inputs, score the handshakes.
    task automatic cycle();
        logic do_pop;
        @(negedge clk);
        if (prev_stall) begin
            check("stall_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
            check("stall_tdata", m_axis_tdata, held.data);
            check("stall_tuser", {24'd0, m_axis_tuser}, {24'd0, held.user});
            check("stall_tlast", {31'd0, m_axis_tlast}, {31'd0, held.last});
        end
        if (hdr_valid) begin
            hdr_seen++;
            if (exp_hdr.size() >= 4) begin
                check("hdr_id", hdr_measure_id, exp_hdr.pop_front());
                check("hdr_count", hdr_measure_count, exp_hdr.pop_front());
                check("hdr_sec", hdr_ts_sec, exp_hdr.pop_front());
                check("hdr_nsec", hdr_ts_nsec, exp_hdr.pop_front());
            end else begin
                check("hdr_extra", {31'd0, hdr_valid}, 32'd0);
            end
        end
        fifo_empty    = (src_q.size() == 0) || ($urandom_range(99) < gap_pct);
        m_axis_tready = ($urandom_range(99) < ready_pct);
        #1;
        if (fifo_rd_en) begin
            check("rd_on_empty", {31'd0, fifo_empty}, 32'd0);
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_beats.size() > 0) begin
                beat_t b;
                b = exp_beats.pop_front();
                check("beat_data", m_axis_tdata, b.data);
                check("beat_user", {24'd0, m_axis_tuser}, {24'd0, b.user});
                check("beat_last", {31'd0, m_axis_tlast}, {31'd0, b.last});
            end else begin
                check("beat_extra", {31'd0, m_axis_tvalid}, 32'd0);
            end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        held.data  = m_axis_tdata;
        held.user  = m_axis_tuser;
        held.last  = m_axis_tlast;
        prev_rd    = fifo_rd_en;
        do_pop     = fifo_rd_en && !fifo_empty && (src_q.size() > 0);
        @(posedge clk);
        #1;
        fifo_dout = do_pop ? src_q.pop_front() : $urandom;
    endtask

    task automatic soft_reset(input string tag);
        @(negedge clk);
        ctrl_reset    = 1'b1;
        fifo_empty    = 1'b1;
        m_axis_tready = 1'b0;
        @(negedge clk);
        ctrl_reset = 1'b0;
        check_zero(tag);
        prev_stall = 1'b0;
        src_q.delete();
        exp_beats.delete();
        exp_hdr.delete();
        exp_hdr_cnt = 0;
        exp_err     = 0;
        exp_frames  = 0;
        hdr_seen    = 0;
    endtask

    task automatic add_frame(input logic [31:0] id, input logic [31:0] cnt, input logic [31:0] sec,
                             input logic [31:0] nsec, input bit ramp, input int magic_at);
        stim_q.push_back(MAGIC);
        stim_q.push_back(32'(FLEN));
        stim_q.push_back(id);
        stim_q.push_back(cnt);
        stim_q.push_back(sec);
        stim_q.push_back(nsec);
        for (int i = 0; i < NPAY; i++) begin
            if (i == magic_at) stim_q.push_back(MAGIC);
            else if (ramp) stim_q.push_back(32'(i));
            else stim_q.push_back($urandom);
        end
    endtask

    // Reference parser over the whole word stream, by absolute word position.
    task automatic build_expect();
        int  i;
        int  n;
        bit  hunting;
        beat_t b;
        i = 0;
        n = stim_q.size();
        hunting = 1'b0;
        while (i < n) begin
            if (stim_q[i] != MAGIC) begin
                if (!hunting) exp_err++;
                hunting = 1'b1;
                i++;
            end else begin
                hunting = 1'b0;
                if (i + 1 >= n) begin
                    i = n;
                end else if (stim_q[i+1] != 32'(FLEN)) begin
                    exp_err++;
                    i += 2;
                end else if (i + FLEN > n) begin
                    i = n;
                end else begin
                    for (int k = 2; k < 6; k++) exp_hdr.push_back(stim_q[i+k]);
                    exp_hdr_cnt++;
                    for (int k = 0; k < NPAY; k++) begin
                        b.data = stim_q[i+6+k];
                        b.user = 8'(k);
                        b.last = (k == NPAY - 1);
                        exp_beats.push_back(b);
                    end
                    exp_frames++;
                    i += FLEN;
                end
            end
        end
    endtask

    task automatic start_test(input int gap, input int rdy);
        build_expect();
        src_q = stim_q;
        stim_q.delete();
        gap_pct   = gap;
        ready_pct = rdy;
    endtask

    task automatic finish_test(input string name);
        int budget;
        budget = 20000;
        while (budget > 0 && (src_q.size() > 0 || exp_beats.size() > 0 || m_axis_tvalid)) begin
            cycle();
            budget--;
        end
        repeat (10) cycle();
        check({name, "_beats_left"}, 32'(exp_beats.size()), 32'd0);
        check({name, "_hdr_left"}, 32'(exp_hdr.size()), 32'd0);
        check({name, "_hdr_pulses"}, 32'(hdr_seen), 32'(exp_hdr_cnt));
        check({name, "_err_cnt"}, {16'd0, stat_err_cnt}, 32'(exp_err));
        check({name, "_frame_cnt"}, stat_frame_cnt, 32'(exp_frames));
        check({name, "_state"}, {30'd0, stat_state}, 32'd0);
        $display("test %s: frames=%0d errs=%0d checks=%0d", name, stat_frame_cnt, stat_err_cnt, n_checks);
    endtask

    initial begin
        int budget;
        resetn        = 1'b0;
        ctrl_reset    = 1'b0;
        fifo_empty    = 1'b1;
        m_axis_tready = 1'b0;
        fifo_dout     = 32'd0;
        prev_stall    = 1'b0;
        prev_rd       = 1'b0;
        gap_pct       = 0;
        ready_pct     = 100;
        repeat (3) @(negedge clk);
        check_zero("por");
        check("por_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        resetn = 1'b1;

        // Clean frame with the ramp payload.
        soft_reset("t1_rst");
        add_frame(32'd5, 32'd1, 32'h10, 32'h20, 1'b1, -1);
        start_test(0, 100);
        finish_test("clean");

        // Leading garbage counts one error while hunting.
        soft_reset("t2_rst");
        for (int i = 0; i < 3; i++) stim_q.push_back($urandom & 32'hFFFF_FF00);
        add_frame($urandom, $urandom, $urandom, $urandom, 1'b0, -1);
        start_test(10, 100);
        finish_test("garbage");
        check("garbage_err_one", {16'd0, stat_err_cnt}, 32'd1);

        // Wrong length word.
        soft_reset("t3_rst");
        stim_q.push_back(MAGIC);
        stim_q.push_back(32'd112);
        start_test(0, 100);
        finish_test("badlen");

        // Backpressure plus source gaps over two frames.
        soft_reset("t4_rst");
        add_frame($urandom, $urandom, $urandom, $urandom, 1'b0, -1);
        add_frame($urandom, $urandom, $urandom, $urandom, 1'b0, -1);
        start_test(40, 30);
        finish_test("stress");

        // Soft reset mid-payload with a read in flight.
        soft_reset("t5_rst");
        add_frame($urandom, $urandom, $urandom, $urandom, 1'b0, -1);
        start_test(0, 100);
        budget = 2000;
        while (budget > 0 && exp_beats.size() > NPAY - 50) begin
            cycle();
            budget--;
        end
        check("midreset_beats", 32'(exp_beats.size()), 32'(NPAY - 50));
        check("midreset_inflight", {31'd0, prev_rd}, 32'd1);
        soft_reset("midreset");
        add_frame($urandom, $urandom, $urandom, $urandom, 1'b0, -1);
        start_test(0, 100);
        finish_test("after_reset");

        // Magic inside the payload is plain data.
        soft_reset("t6_rst");
        add_frame($urandom, $urandom, $urandom, $urandom, 1'b0, 10);
        start_test(20, 50);
        finish_test("pay_magic");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
